// File: rtl/fifo_rd_pkg.sv
// Shared constants and the output-buffer state type for the FIFO read controller.
package fifo_rd_pkg;

  localparam int DEFAULT_DATA_WIDTH = 8;
  localparam int DEFAULT_CNT_WIDTH  = 16;

  // Buffer state is encoded as its occupancy, so it can be used directly in credit arithmetic.
  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    TWO   = 2'd2
  } buf_state_e;

endpackage

// File: rtl/fifo_rd_ctrl_if.sv
// FIFO read-side and downstream valid/ready signals of fifo_rd_ctrl.
// The master modport is the controller; the slave modport is the FIFO plus consumer.
interface fifo_rd_ctrl_if import fifo_rd_pkg::*; #(
  parameter int DATA_WIDTH = DEFAULT_DATA_WIDTH
);
  logic                  rEmpty;
  logic [DATA_WIDTH-1:0] rData;
  logic                  rinc;
  logic [DATA_WIDTH-1:0] out_data;
  logic                  out_valid;
  logic                  out_ready;

  modport master (
    input  rEmpty, rData, out_ready,
    output rinc, out_data, out_valid
  );

  modport slave (
    output rEmpty, rData, out_ready,
    input  rinc, out_data, out_valid
  );
endinterface

// File: rtl/fifo_rd_skid.sv
// Two-entry output buffer: head entry drives the output, tail entry absorbs one word of backpressure.
module fifo_rd_skid import fifo_rd_pkg::*; #(
  parameter int DATA_WIDTH = DEFAULT_DATA_WIDTH
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  push_i,
  input  logic [DATA_WIDTH-1:0] data_in_i,
  input  logic                  pop_i,
  output logic [DATA_WIDTH-1:0] data_out_o,
  output logic                  valid_o,
  output buf_state_e            occupancy_o
);

  buf_state_e            state_q, state_d;
  logic [DATA_WIDTH-1:0] head_q, head_d;
  logic [DATA_WIDTH-1:0] tail_q, tail_d;

  always_comb begin
    // NOTE: every next-state variable gets a default first, so no path leaves one unassigned (no latch).
    state_d = state_q;
    head_d  = head_q;
    tail_d  = tail_q;
    unique case (state_q)
      EMPTY: begin
        if (push_i) begin
          head_d  = data_in_i;
          state_d = ONE;
        end
      end
      ONE: begin
        if (push_i && pop_i) begin
          head_d = data_in_i;
        end else if (push_i) begin
          tail_d  = data_in_i;
          state_d = TWO;
        end else if (pop_i) begin
          state_d = EMPTY;
        end
      end
      TWO: begin
        if (pop_i) begin
          head_d = tail_q;
          if (push_i) tail_d = data_in_i;
          else        state_d = ONE;
        end
      end
      default: state_d = EMPTY;
    endcase
  end

  always_ff @(posedge clk) begin
    // NOTE: non-blocking assignments keep every flop sampling pre-edge values regardless of block order.
    if (rst) begin
      state_q <= EMPTY;
      // NOTE: the two data entries are reset too, because out_data must read zero after reset.
      head_q  <= '0;
      tail_q  <= '0;
    end else begin
      state_q <= state_d;
      head_q  <= head_d;
      tail_q  <= tail_d;
    end
  end

  assign data_out_o  = head_q;
  assign valid_o     = (state_q != EMPTY);
  assign occupancy_o = state_q;

endmodule

// File: rtl/fifo_rd_ctrl.sv
// FIFO read-side controller: issues rinc against buffer credit and presents words on valid/ready.
// Optional read-statistics counter (rd_count) is built when FIFO_RD_STATS_EN is defined.
module fifo_rd_ctrl import fifo_rd_pkg::*; #(
  parameter int DATA_WIDTH = DEFAULT_DATA_WIDTH,
  parameter int CNT_WIDTH  = DEFAULT_CNT_WIDTH
) (
  input  logic                 rclk,
  input  logic                 rrst,
  input  logic                 rd_en,
  fifo_rd_ctrl_if.master       bus
`ifdef FIFO_RD_STATS_EN
  ,
  output logic [CNT_WIDTH-1:0] rd_count
`endif
);

  logic       rd_pend_q;
  logic       skid_valid;
  logic       pop;
  logic [2:0] committed;
  buf_state_e occ;

  assign pop = skid_valid & bus.out_ready;

  // Words buffered plus the one in flight must leave room, counting the slot a pop frees this cycle.
  assign committed = 3'(occ) + {2'b00, rd_pend_q};
  assign bus.rinc  = rd_en & ~bus.rEmpty & ~rrst & (committed < (3'd2 + {2'b00, pop}));

  always_ff @(posedge rclk) begin
    if (rrst) rd_pend_q <= 1'b0;
    else      rd_pend_q <= bus.rinc;
  end

  fifo_rd_skid #(
    .DATA_WIDTH (DATA_WIDTH)
  ) u_skid (
    .clk         (rclk),
    .rst         (rrst),
    .push_i      (rd_pend_q),
    .data_in_i   (bus.rData),
    .pop_i       (pop),
    .data_out_o  (bus.out_data),
    .valid_o     (skid_valid),
    .occupancy_o (occ)
  );

  assign bus.out_valid = skid_valid;

`ifdef FIFO_RD_STATS_EN
  logic [CNT_WIDTH-1:0] cnt_q;

  always_ff @(posedge rclk) begin
    if (rrst)     cnt_q <= '0;
    else if (pop) cnt_q <= cnt_q + 1'b1;
  end

  assign rd_count = cnt_q;
`endif

endmodule

// File: tb/tb_fifo_rd_ctrl.sv
// Scoreboard bench for fifo_rd_ctrl: a small FIFO model feeds the DUT, a monitor checks delivered words.
module tb_fifo_rd_ctrl;
  import fifo_rd_pkg::*;

  logic rclk = 1'b0;
  logic rrst;
  logic rd_en;
  logic force_empty = 1'b0;
  logic flush = 1'b0;
`ifdef FIFO_RD_STATS_EN
  logic [3:0] rd_count;
`endif

  logic [7:0] tb_mem [256];
  int         wr_ptr = 0;
  int         rd_ptr = 0;
  logic [7:0] exp_q [$];

  int n_cmp = 0;
  int n_fail = 0;
  int rinc_total = 0;
  int hs_total = 0;

  fifo_rd_ctrl_if #(.DATA_WIDTH(8)) bus ();

  fifo_rd_ctrl #(
    .DATA_WIDTH (8),
    .CNT_WIDTH  (4)
  ) dut (
    .rclk     (rclk),
    .rrst     (rrst),
    .rd_en    (rd_en),
    .bus      (bus)
`ifdef FIFO_RD_STATS_EN
    ,
    .rd_count (rd_count)
`endif
  );

  always #5 rclk = ~rclk;

  assign bus.rEmpty = force_empty || (rd_ptr == wr_ptr);

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  // FIFO model: rData is valid the cycle after rinc; flush discards unread words.
  initial bus.rData = '0;
  always @(posedge rclk) begin
    if (flush) begin
      rd_ptr <= wr_ptr;
    end else if (bus.rinc) begin
      bus.rData <= tb_mem[rd_ptr];
      rd_ptr    <= rd_ptr + 1;
    end
  end

  // Monitor: sampled on the falling edge, where inputs and outputs both hold their next-edge values.
  always @(negedge rclk) begin
    if (!rrst) begin
      if (bus.rinc) begin
        rinc_total++;
        check("rinc_while_empty", 32'(bus.rEmpty), 32'd0);
      end
      if (bus.out_valid && bus.out_ready) begin
        hs_total++;
        if (exp_q.size() == 0) begin
          n_cmp++;
          n_fail++;
          $display("FAIL sb_unexpected: got word %0h, expected no word", bus.out_data);
        end else begin
          check("sb_data", 32'(bus.out_data), 32'(exp_q.pop_front()));
        end
      end
    end
  end

  task automatic load(input logic [7:0] base, input int n);
    for (int i = 0; i < n; i++) begin
      logic [7:0] v;
      v = base + 8'(i);
      tb_mem[wr_ptr] = v;
      wr_ptr++;
      exp_q.push_back(v);
    end
  endtask

  task automatic drain(input string name, input int max_cycles);
    int n;
    n = 0;
    while (exp_q.size() != 0 && n < max_cycles) begin
      @(posedge rclk); #1;
      n++;
    end
    check(name, 32'(exp_q.size()), 32'd0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got no end of test, expected finish within 100000 time units");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int n;
    int k;
    int base_rinc;
    int base_hs;

    // Reset with a word available: nothing may be read or presented.
    rrst = 1'b1;
    rd_en = 1'b1;
    bus.out_ready = 1'b0;
    tb_mem[wr_ptr] = 8'h55;
    wr_ptr++;
    repeat (2) @(posedge rclk);
    @(negedge rclk);
    check("rst_rempty_present", 32'(bus.rEmpty), 32'd0);
    check("rst_rinc", 32'(bus.rinc), 32'd0);
    check("rst_out_valid", 32'(bus.out_valid), 32'd0);
    check("rst_out_data", 32'(bus.out_data), 32'd0);
`ifdef FIFO_RD_STATS_EN
    check("rst_rd_count", 32'(rd_count), 32'd0);
`endif
    @(posedge rclk); #1;
    flush = 1'b1;
    @(posedge rclk); #1;
    flush = 1'b0;

    // Streaming 0x01..0x08 with the consumer always ready.
    rrst = 1'b0;
    bus.out_ready = 1'b1;
    load(8'h01, 8);
    n = 0;
    @(negedge rclk);
    while (!bus.rinc && n < 10) begin
      @(negedge rclk);
      n++;
    end
    check("stream_first_rinc", 32'(bus.rinc), 32'd1);
    k = 0;
    while (!bus.out_valid && k < 10) begin
      @(negedge rclk);
      k++;
    end
    check("stream_latency", 32'(k), 32'd2);
    for (int i = 0; i < 8; i++) begin
      check("stream_back_to_back", 32'(bus.out_valid), 32'd1);
      @(negedge rclk);
    end
    check("stream_done_valid", 32'(bus.out_valid), 32'd0);
    check("stream_all_out", 32'(exp_q.size()), 32'd0);
`ifdef FIFO_RD_STATS_EN
    check("stream_rd_count", 32'(rd_count), 32'd8);
`endif

    // Backpressure: only two words may be fetched, head held at 0xA0.
    @(posedge rclk); #1;
    bus.out_ready = 1'b0;
    base_rinc = rinc_total;
    base_hs = hs_total;
    load(8'hA0, 4);
    repeat (6) @(negedge rclk);
    check("bp_rinc_pulses", 32'(rinc_total - base_rinc), 32'd2);
    check("bp_occupancy", 32'(dut.u_skid.occupancy_o), 32'(TWO));
    check("bp_out_valid", 32'(bus.out_valid), 32'd1);
    check("bp_head", 32'(bus.out_data), 32'hA0);
    @(negedge rclk);
    check("bp_head_held", 32'(bus.out_data), 32'hA0);
    @(posedge rclk); #1;
    bus.out_ready = 1'b1;
    drain("bp_drain", 20);
    repeat (3) @(negedge rclk);
    check("bp_word_count", 32'(hs_total - base_hs), 32'd4);
    check("bp_idle_valid", 32'(bus.out_valid), 32'd0);
`ifdef FIFO_RD_STATS_EN
    check("bp_rd_count", 32'(rd_count), 32'd12);
`endif

    // Empty flag toggling every cycle: each word exactly once, no read while empty.
    @(posedge rclk); #1;
    base_hs = hs_total;
    load(8'h30, 6);
    for (int i = 0; i < 60 && exp_q.size() != 0; i++) begin
      @(posedge rclk); #1;
      force_empty = !force_empty;
    end
    force_empty = 1'b0;
    check("toggle_drain", 32'(exp_q.size()), 32'd0);
    repeat (3) @(negedge rclk);
    check("toggle_word_count", 32'(hs_total - base_hs), 32'd6);
`ifdef FIFO_RD_STATS_EN
    check("toggle_rd_count_wrap", 32'(rd_count), 32'd2);
`endif

    // Reset in the middle of a stream with a word in flight.
    @(posedge rclk); #1;
    load(8'h60, 16);
    repeat (4) @(negedge rclk);
    check("mid_rd_pend", 32'(dut.rd_pend_q), 32'd1);
    @(posedge rclk); #1;
    rrst = 1'b1;
    flush = 1'b1;
    exp_q.delete();
    @(posedge rclk); #1;
    flush = 1'b0;
    @(negedge rclk);
    check("mid_rst_out_valid", 32'(bus.out_valid), 32'd0);
    check("mid_rst_rinc", 32'(bus.rinc), 32'd0);
`ifdef FIFO_RD_STATS_EN
    check("mid_rst_rd_count", 32'(rd_count), 32'd0);
`endif
    @(posedge rclk); #1;
    rrst = 1'b0;
    repeat (5) @(negedge rclk);
    check("mid_rst_no_stale", 32'(bus.out_valid), 32'd0);
    @(posedge rclk); #1;
    load(8'h7E, 2);
    drain("mid_rst_resume", 20);

    // Seventeen handshakes from a clean reset.
    @(posedge rclk); #1;
    rrst = 1'b1;
    repeat (2) @(posedge rclk);
    #1;
    rrst = 1'b0;
    load(8'h80, 17);
    drain("wrap_drain", 60);
    repeat (2) @(negedge rclk);
`ifdef FIFO_RD_STATS_EN
    check("wrap_rd_count", 32'(rd_count), 32'd1);
`endif
    check("wrap_idle_valid", 32'(bus.out_valid), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
